// File: rtl/int_clk_div_if.sv
// -----------------------------------------------------------------------------
// int_clk_div_if
// Groups the control and output signals of the integer clock divider.
//   i_clk_en     divider enable (0 = bypass once the current period ends)
//   i_div_ratio  requested divide ratio N (0/1 = bypass)
//   o_div_clk    divided clock (reference clock while bypassed)
// master : the controlling side (drives enable/ratio, observes the clock)
// slave  : the divider itself
// -----------------------------------------------------------------------------
interface int_clk_div_if #(
    parameter int RATIO_WD = 8
);
    logic                i_clk_en;
    logic [RATIO_WD-1:0] i_div_ratio;
    logic                o_div_clk;

    modport master (
        output i_clk_en,
        output i_div_ratio,
        input  o_div_clk
    );

    modport slave (
        input  i_clk_en,
        input  i_div_ratio,
        output o_div_clk
    );
endinterface

// File: rtl/int_clk_div.sv
// -----------------------------------------------------------------------------
// int_clk_div
// Integer clock divider for the RX/oversampling domain. Produces a clock with
// period N reference cycles (low phase L = N - floor(N/2), high phase
// H = floor(N/2)), passes the reference clock straight through for N < 2 or
// when disabled, and only adopts a new ratio or enable at a period boundary so
// the output never shows a truncated period.
// Ports:
//   i_ref_clk  reference clock, all state updates on its rising edge
//   i_rst_n    asynchronous active-low reset
//   bus        int_clk_div_if.slave: i_clk_en, i_div_ratio in; o_div_clk out
// -----------------------------------------------------------------------------
module int_clk_div #(
    parameter int RATIO_WD = 8
) (
    input  logic         i_ref_clk,
    input  logic         i_rst_n,
    int_clk_div_if.slave bus
);

    typedef enum logic {
        ST_BYPASS = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [RATIO_WD-1:0] act_ratio_q, act_ratio_d;
    logic [RATIO_WD-1:0] cnt_q, cnt_d;
    logic                div_q, div_d;

    logic [RATIO_WD-1:0] half_h_s;
    logic [RATIO_WD-1:0] half_l_s;
    logic                ratio_ok_s;

    // Phase lengths from the latched ratio; the low phase takes the extra cycle
    // of an odd ratio. In RUN the latched ratio is always >= 2, so H - 1 and
    // L - 1 never underflow.
    assign half_h_s   = act_ratio_q >> 1;
    assign half_l_s   = act_ratio_q - half_h_s;
    assign ratio_ok_s = (bus.i_div_ratio >= RATIO_WD'(2));

    // Next-state, counter and divided-clock decode.
    always_comb begin
        state_d     = state_q;
        act_ratio_d = act_ratio_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        case (state_q)
            ST_BYPASS: begin
                act_ratio_d = bus.i_div_ratio;
                cnt_d       = {RATIO_WD{1'b0}};
                div_d       = 1'b0;
                if (bus.i_clk_en && ratio_ok_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_BYPASS;
                end
            end
            ST_RUN: begin
                if (!div_q) begin
                    if (cnt_q == (half_l_s - RATIO_WD'(1))) begin
                        div_d = 1'b1;
                        cnt_d = {RATIO_WD{1'b0}};
                    end else begin
                        cnt_d = cnt_q + RATIO_WD'(1);
                    end
                end else begin
                    if (cnt_q == (half_h_s - RATIO_WD'(1))) begin
                        // Period boundary: the only point where ratio and
                        // enable are sampled while running.
                        div_d       = 1'b0;
                        cnt_d       = {RATIO_WD{1'b0}};
                        act_ratio_d = bus.i_div_ratio;
                        if (bus.i_clk_en && ratio_ok_s) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_BYPASS;
                        end
                    end else begin
                        cnt_d = cnt_q + RATIO_WD'(1);
                    end
                end
            end
            default: begin
                state_d     = ST_BYPASS;
                act_ratio_d = RATIO_WD'(1);
                cnt_d       = {RATIO_WD{1'b0}};
                div_d       = 1'b0;
            end
        endcase
    end

    // State, latched ratio, phase counter and divided-clock registers.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_BYPASS;
            act_ratio_q <= RATIO_WD'(1);
            cnt_q       <= {RATIO_WD{1'b0}};
            div_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_ratio_q <= act_ratio_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
        end
    end

    // In bypass (and throughout reset, since reset forces BYPASS) the reference
    // clock is passed through; the mux only switches on a rising edge.
    assign bus.o_div_clk = (state_q == ST_RUN) ? div_q : i_ref_clk;

endmodule
